// File: rtl/am_bank_responder_if.sv
// ---------------------------------------------------------------------------
// am_bank_responder_if
// Per-bank dual-port request bus between the router (master) and one
// activation-memory bank (slave).
//   addrN        word address of port N
//   csN          port N access enable
//   rwN          port N direction, 0 = read, 1 = write
//   wdataN       port N write data, P lanes of W bits
//   byteenableN  port N byte write enables
//   bank_csN     port N lane selects
//   rdataN       port N registered read data (driven by the bank)
// ---------------------------------------------------------------------------
interface am_bank_responder_if #(
    parameter int P = 64,
    parameter int W = 8
);
    logic [4:0]         addr0;
    logic               cs0;
    logic               rw0;
    logic [P*W-1:0]     wdata0;
    logic [P*W/8-1:0]   byteenable0;
    logic [P-1:0]       bank_cs0;
    logic [P*W-1:0]     rdata0;

    logic [4:0]         addr1;
    logic               cs1;
    logic               rw1;
    logic [P*W-1:0]     wdata1;
    logic [P*W/8-1:0]   byteenable1;
    logic [P-1:0]       bank_cs1;
    logic [P*W-1:0]     rdata1;

    modport master (
        output addr0, cs0, rw0, wdata0, byteenable0, bank_cs0,
        output addr1, cs1, rw1, wdata1, byteenable1, bank_cs1,
        input  rdata0, rdata1
    );

    modport slave (
        input  addr0, cs0, rw0, wdata0, byteenable0, bank_cs0,
        input  addr1, cs1, rw1, wdata1, byteenable1, bank_cs1,
        output rdata0, rdata1
    );
endinterface

// File: rtl/am_bank_responder.sv
// ---------------------------------------------------------------------------
// am_bank_responder
// Activation-memory bank with two independent ports (1-cycle registered
// read), a zero-clear sequencer that runs after reset and on clear_req, and
// accounting of same-address dual-write collisions.
//
// Ports:
//   clk            clock
//   rst            synchronous active-high reset
//   bus            dual-port request bus (slave side), see am_bank_responder_if
//   clear_req      one-cycle pulse: zero-clear the whole bank
//   init_done      high while the bank accepts accesses
//   collision_cnt  saturating count of same-address dual-write cycles
//   collision      registered pulse, high the cycle after a collision
//
// Optional feature (macro AM_BANK_RDW_FWD_EN): a read on one port to the
// address written by the other port in the same cycle returns the newly
// written bytes merged with the stored ones. Without the macro the bank is
// strictly read-first and no forwarding logic exists.
// ---------------------------------------------------------------------------
module am_bank_responder #(
    parameter int P     = 64,
    parameter int W     = 8,
    parameter int DEPTH = 32,
    parameter int CW    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    am_bank_responder_if.slave   bus,
    input  logic                 clear_req,
    output logic                 init_done,
    output logic [CW-1:0]        collision_cnt,
    output logic                 collision
);
    localparam int DW  = P * W;
    localparam int NB  = DW / 8;
    localparam int BPL = W / 8;

    localparam logic [0:0] S_CLR   = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;
    localparam logic [4:0] LAST_ADDR = 5'(DEPTH - 1);

    logic [DW-1:0]  r_mem [0:DEPTH-1];
    logic [0:0]     r_state;
    logic [4:0]     r_clr_addr;
    logic           r_init_done;
    logic           r_collision;
    logic [CW-1:0]  r_collision_cnt;
    logic [DW-1:0]  r_rdata0;
    logic [DW-1:0]  r_rdata1;

    logic           w_ready;
    logic           w_addr_ok0, w_addr_ok1;
    logic           w_same_addr;
    logic           w_wr0, w_wr1, w_rd0, w_rd1;
    logic [NB-1:0]  w_bm0, w_bm1;      // byte enable qualified by lane select
    logic [NB-1:0]  w_em0, w_em1;      // bytes actually written this cycle
    logic [DW-1:0]  w_lm0, w_lm1;      // lane select expanded to bits
    logic [DW-1:0]  w_mem_q0, w_mem_q1;
    logic [DW-1:0]  w_rd_val0, w_rd_val1;
    logic           w_collision;

    assign w_ready = (r_state == S_READY);

    // Only banks shallower than the 5-bit address space need a range check.
    generate
        if (DEPTH < 32) begin : g_range
            assign w_addr_ok0 = (bus.addr0 < 5'(DEPTH));
            assign w_addr_ok1 = (bus.addr1 < 5'(DEPTH));
        end else begin : g_full
            assign w_addr_ok0 = 1'b1;
            assign w_addr_ok1 = 1'b1;
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_byte
            assign w_bm0[gi] = bus.byteenable0[gi] & bus.bank_cs0[gi / BPL];
            assign w_bm1[gi] = bus.byteenable1[gi] & bus.bank_cs1[gi / BPL];
        end
        for (gi = 0; gi < P; gi++) begin : g_lane
            assign w_lm0[gi*W +: W] = {W{bus.bank_cs0[gi]}};
            assign w_lm1[gi*W +: W] = {W{bus.bank_cs1[gi]}};
        end
    endgenerate

    assign w_same_addr = (bus.addr0 == bus.addr1);
    assign w_wr0 = w_ready & bus.cs0 & bus.rw0 & w_addr_ok0;
    assign w_wr1 = w_ready & bus.cs1 & bus.rw1 & w_addr_ok1;
    assign w_rd0 = bus.cs0 & ~bus.rw0;
    assign w_rd1 = bus.cs1 & ~bus.rw1;

    // Port 0 owns every byte it enables; port 1 only fills the remaining ones
    // when both hit the same word, so the two write loops never overlap.
    assign w_em0 = w_wr0 ? w_bm0 : '0;
    assign w_em1 = (w_wr1 ? w_bm1 : '0) & ~(w_same_addr ? w_em0 : '0);

    // Counted on the raw (pre-priority) masks: both ports must really write.
    assign w_collision = w_wr0 & w_wr1 & w_same_addr & (|w_bm0) & (|w_bm1);

    assign w_mem_q0 = w_addr_ok0 ? r_mem[bus.addr0] : '0;
    assign w_mem_q1 = w_addr_ok1 ? r_mem[bus.addr1] : '0;

`ifdef AM_BANK_RDW_FWD_EN
    logic [DW-1:0] w_em0_bits, w_em1_bits;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_fwd
            assign w_em0_bits[gi*8 +: 8] = {8{w_em0[gi] & w_same_addr}};
            assign w_em1_bits[gi*8 +: 8] = {8{w_em1[gi] & w_same_addr}};
        end
    endgenerate
    assign w_rd_val0 = ((w_mem_q0 & ~w_em1_bits) | (bus.wdata1 & w_em1_bits)) & w_lm0;
    assign w_rd_val1 = ((w_mem_q1 & ~w_em0_bits) | (bus.wdata0 & w_em0_bits)) & w_lm1;
`else
    assign w_rd_val0 = w_mem_q0 & w_lm0;
    assign w_rd_val1 = w_mem_q1 & w_lm1;
`endif

    // Clear sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_CLR;
            r_clr_addr  <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                S_CLR: begin
                    if (r_clr_addr == LAST_ADDR) begin
                        r_state     <= S_READY;
                        r_clr_addr  <= '0;
                        r_init_done <= 1'b1;
                    end else begin
                        r_clr_addr <= r_clr_addr + 5'd1;
                    end
                end
                default: begin
                    if (clear_req) begin
                        r_state     <= S_CLR;
                        r_clr_addr  <= '0;
                        r_init_done <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Storage: no reset, the clear sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == S_CLR) begin
                r_mem[r_clr_addr] <= '0;
            end else begin
                for (int b = 0; b < NB; b++) begin
                    if (w_em0[b]) r_mem[bus.addr0][b*8 +: 8] <= bus.wdata0[b*8 +: 8];
                    if (w_em1[b]) r_mem[bus.addr1][b*8 +: 8] <= bus.wdata1[b*8 +: 8];
                end
            end
        end
    end

    // Read registers: zeroed while clearing so the bank comes out of a clear
    // with rdata = 0 regardless of what was read before.
    always_ff @(posedge clk) begin
        if (rst || r_state == S_CLR) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_rd0) r_rdata0 <= w_rd_val0;
            if (w_rd1) r_rdata1 <= w_rd_val1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_collision     <= 1'b0;
            r_collision_cnt <= '0;
        end else begin
            r_collision <= w_collision;
            if (w_collision && r_collision_cnt != '1) begin
                r_collision_cnt <= r_collision_cnt + 1'b1;
            end
        end
    end

    // Gate on state so the first clear cycle already shows zero.
    assign bus.rdata0    = w_ready ? r_rdata0 : '0;
    assign bus.rdata1    = w_ready ? r_rdata1 : '0;
    assign init_done     = r_init_done;
    assign collision     = r_collision;
    assign collision_cnt = r_collision_cnt;
endmodule

// File: tb/tb_am_bank_responder.sv
// ---------------------------------------------------------------------------
// tb_am_bank_responder
// Self-checking bench for am_bank_responder. A behavioural bank model tracks
// memory contents, clear progress and the collision counter; read results are
// queued when a read is driven and compared when the DUT presents them.
// ---------------------------------------------------------------------------
module tb_am_bank_responder;
    localparam int P     = 64;
    localparam int W     = 8;
    localparam int DEPTH = 32;
    localparam int CW    = 8;
    localparam int DW    = P * W;
    localparam int NB    = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear_req;
    logic          init_done;
    logic [CW-1:0] collision_cnt;
    logic          collision;

    am_bank_responder_if #(.P(P), .W(W)) bus ();

    am_bank_responder #(.P(P), .W(W), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus.slave),
        .clear_req     (clear_req),
        .init_done     (init_done),
        .collision_cnt (collision_cnt),
        .collision     (collision)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] m_mem [0:DEPTH-1];
    bit            m_ready;
    int            m_left;
    int            m_cnt;
    logic [DW-1:0] m_hold0, m_hold1;
    int            checks;
    int            failures;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] fill(input logic [7:0] v);
        return {NB{v}};
    endfunction

    function automatic logic [NB-1:0] eff_bytes(input logic [NB-1:0] be, input logic [P-1:0] lanes);
        logic [NB-1:0] r;
        for (int b = 0; b < NB; b++) r[b] = be[b] & lanes[b / (W / 8)];
        return r;
    endfunction

    function automatic logic [DW-1:0] lane_gate(input logic [DW-1:0] d, input logic [P-1:0] lanes);
        logic [DW-1:0] r;
        r = d;
        for (int l = 0; l < P; l++) if (!lanes[l]) r[l*W +: W] = '0;
        return r;
    endfunction

    task automatic idle();
        bus.cs0 = 1'b0;
        bus.cs1 = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic drive(input int port, input bit rw, input logic [4:0] a,
                         input logic [DW-1:0] d, input logic [NB-1:0] be, input logic [P-1:0] lanes);
        if (port == 0) begin
            bus.cs0 = 1'b1; bus.rw0 = rw; bus.addr0 = a;
            bus.wdata0 = d; bus.byteenable0 = be; bus.bank_cs0 = lanes;
        end else begin
            bus.cs1 = 1'b1; bus.rw1 = rw; bus.addr1 = a;
            bus.wdata1 = d; bus.byteenable1 = be; bus.bank_cs1 = lanes;
        end
    endtask

    // One clock: update the model from the driven inputs, clock, check outputs.
    task automatic step();
        logic [DW-1:0] rv;
        logic [NB-1:0] e0, e1;
        bit            w0, w1, exp_coll, got0, got1;
        exp_t          e;
        exp_coll = 1'b0;
        if (rst) begin
            m_ready = 1'b0;
            m_left  = DEPTH;
            m_cnt   = 0;
        end else if (!m_ready) begin
            m_mem[DEPTH - m_left] = '0;
            m_left--;
            if (m_left == 0) m_ready = 1'b1;
        end else begin
            w0 = bus.cs0 && bus.rw0;
            w1 = bus.cs1 && bus.rw1;
            e0 = w0 ? eff_bytes(bus.byteenable0, bus.bank_cs0) : '0;
            e1 = w1 ? eff_bytes(bus.byteenable1, bus.bank_cs1) : '0;
            if (bus.cs0 && !bus.rw0) begin
                rv = m_mem[bus.addr0];
`ifdef AM_BANK_RDW_FWD_EN
                if (w1 && bus.addr1 == bus.addr0)
                    for (int b = 0; b < NB; b++) if (e1[b]) rv[b*8 +: 8] = bus.wdata1[b*8 +: 8];
`endif
                sb.push_back('{0, lane_gate(rv, bus.bank_cs0)});
            end
            if (bus.cs1 && !bus.rw1) begin
                rv = m_mem[bus.addr1];
`ifdef AM_BANK_RDW_FWD_EN
                if (w0 && bus.addr1 == bus.addr0)
                    for (int b = 0; b < NB; b++) if (e0[b]) rv[b*8 +: 8] = bus.wdata0[b*8 +: 8];
`endif
                sb.push_back('{1, lane_gate(rv, bus.bank_cs1)});
            end
            // Port 1 first, then port 0 on top: port 0 wins shared bytes.
            for (int b = 0; b < NB; b++) if (e1[b]) m_mem[bus.addr1][b*8 +: 8] = bus.wdata1[b*8 +: 8];
            for (int b = 0; b < NB; b++) if (e0[b]) m_mem[bus.addr0][b*8 +: 8] = bus.wdata0[b*8 +: 8];
            if (w0 && w1 && bus.addr0 == bus.addr1 && e0 != '0 && e1 != '0) begin
                exp_coll = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
            if (clear_req) begin
                m_ready = 1'b0;
                m_left  = DEPTH;
            end
        end
        @(posedge clk);
        #1;
        got0 = 1'b0;
        got1 = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.port == 0) begin m_hold0 = e.data; got0 = 1'b1; end
            else             begin m_hold1 = e.data; got1 = 1'b1; end
            $display("txn read port=%0d data[63:0]=%016h", e.port, e.data[63:0]);
        end
        if (!m_ready) begin
            m_hold0 = '0;
            m_hold1 = '0;
        end
        check(got0 ? "rdata0" : "rdata0_hold", bus.rdata0, m_hold0);
        check(got1 ? "rdata1" : "rdata1_hold", bus.rdata1, m_hold1);
        check("init_done", DW'(init_done), DW'(m_ready));
        check("collision", DW'(collision), DW'(exp_coll));
        check("collision_cnt", DW'(collision_cnt), DW'(m_cnt));
        idle();
    endtask

    initial begin
        logic [DW-1:0] rd;
        checks = 0;
        failures = 0;
        m_hold0 = '0;
        m_hold1 = '0;
        m_ready = 1'b0;
        m_left = DEPTH;
        m_cnt = 0;
        for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
        rst = 1'b1;
        bus.addr0 = '0; bus.rw0 = 1'b0; bus.wdata0 = '0; bus.byteenable0 = '0; bus.bank_cs0 = '0;
        bus.addr1 = '0; bus.rw1 = 1'b0; bus.wdata1 = '0; bus.byteenable1 = '0; bus.bank_cs1 = '0;
        idle();

        // Reset and initial clear.
        step(); step();
        rst = 1'b0;
        repeat (DEPTH) step();
        drive(0, 0, 5'd7, '0, '0, '1); step();

        // Port 0 write, port 1 read back.
        drive(0, 1, 5'd3, fill(8'hA5), '1, '1); step();
        drive(1, 0, 5'd3, '0, '0, '1); step();

        // Lane select and byte enable masking on write and read.
        drive(0, 1, 5'd5, fill(8'hFF), ~64'h1, ~64'h4); step();
        drive(0, 0, 5'd5, '0, '0, '1); step();
        drive(0, 0, 5'd5, '0, '0, ~64'h10); step();

        // Same-address dual write with port 0 priority, then saturation.
        drive(0, 1, 5'd9, fill(8'h11), 64'h0000_0000_FFFF_FFFF, '1);
        drive(1, 1, 5'd9, fill(8'h22), '1, '1); step();
        drive(0, 0, 5'd9, '0, '0, '1); step();
        for (int i = 0; i < 299; i++) begin
            drive(0, 1, 5'd9, fill(8'h11), 64'h0000_0000_FFFF_FFFF, '1);
            drive(1, 1, 5'd9, fill(8'h22), '1, '1); step();
        end

        // Read/write same address across ports.
        drive(0, 1, 5'd4, fill(8'h33), '1, '1); step();
        drive(0, 1, 5'd4, fill(8'h44), '1, '1);
        drive(1, 0, 5'd4, '0, '0, '1); step();
        step();

        // Different-address dual write; same-address dual reads.
        drive(0, 1, 5'd10, fill(8'h5A), '1, '1);
        drive(1, 1, 5'd11, fill(8'hC3), '1, '1); step();
        drive(0, 0, 5'd10, '0, '0, '1); drive(1, 0, 5'd10, '0, '0, '1); step();
        drive(0, 0, 5'd11, '0, '0, '1); drive(1, 0, 5'd11, '0, '0, '1); step();

        // Clear request; a read issued mid-clear must not show up.
        clear_req = 1'b1; step();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 3) drive(0, 0, 5'd9, '0, '0, '1);
            step();
        end
        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 0, 5'(a), '0, '0, '1);
            drive(1, 0, 5'(DEPTH - 1 - a), '0, '0, '1); step();
        end

        // Refill, clear, reset at clear cycle 10, full restart.
        drive(0, 1, 5'd2, fill(8'h77), '1, '1); step();
        clear_req = 1'b1; step();
        repeat (10) step();
        rst = 1'b1; step();
        rst = 1'b0;
        repeat (DEPTH) step();
        drive(0, 0, 5'd2, '0, '0, '1); drive(1, 0, 5'd3, '0, '0, '1); step();

        // Random dual-port traffic.
        for (int i = 0; i < 250; i++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 3) != 0) begin
                    for (int k = 0; k < DW / 32; k++) rd[k*32 +: 32] = $urandom;
                    drive(p, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), rd,
                          ($urandom_range(0, 1) == 1) ? '1 : {$urandom, $urandom},
                          ($urandom_range(0, 2) == 0) ? {$urandom, $urandom} : '1);
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
